periodic_pulse_gen: RTL
=======================

Name: periodic_pulse_gen

Overview:
Parametrised multi-channel periodic pulse and heartbeat generator for board-level sequencing, e.g. periodic PSRAM controller resets, LED heartbeats and test-trigger strobes. It also provides a free-running divided clock for downstream controllers. Each of NUM_CH channels has its own period, pulse width and run mode (continuous or one-shot). Configuration changes apply glitch-free at period boundaries. Sits in the top level between sys_clk and the PSRAM/LED logic.

Parameters:
NUM_CH, 3, number of independent channels (>=1)
CNT_W, 32, width of each channel's period/width/counter fields
DIV, 2, divider ratio for clk_div; even, >=2
ACT_LOW, 0, 1 = pulse outputs active-low (idle high, reset value high)

Ports:
sys_clk  in  1  system clock; all logic on rising edge
sys_reset  in  1  asynchronous, active-high reset
en  in  NUM_CH  per-channel enable; low forces the channel to IDLE
start  in  NUM_CH  per-channel single-cycle start request
oneshot  in  NUM_CH  per-channel mode, sampled at start: 1 = one period then DONE, 0 = continuous
cfg_load  in  NUM_CH  single-cycle strobe that latches period/width into the channel's shadow register
cfg_period  in  NUM_CH*CNT_W  period in cycles; channel i at bits [i*CNT_W +: CNT_W]
cfg_width  in  NUM_CH*CNT_W  pulse width in cycles, same packing
pulse  out  NUM_CH  pulse output (polarity set by ACT_LOW)
wrap  out  NUM_CH  one-cycle strobe on the last cycle of each period
toggle  out  NUM_CH  heartbeat; inverts on every wrap
busy  out  NUM_CH  channel is in RUN
done  out  NUM_CH  channel is in DONE (one-shot complete)
clk_div  out  1  sys_clk divided by DIV, ~50% duty, free-running

Behaviour:
- Reset (async, any time, including mid-period):
  - all channels go to IDLE; cnt=0
  - shadow and active period/width = 0
  - pulse = inactive (ACT_LOW ? 1 : 0); wrap=0, toggle=0, busy=0, done=0, clk_div=0
- Divider: a counter 0..DIV/2-1 runs every cycle; clk_div inverts when it reaches DIV/2-1. DIV=2 gives sys_clk/2. Unaffected by en/start.
- Per-channel FSM states: IDLE, RUN, DONE.
  - IDLE -> RUN: cycle after en=1, start=1 and active period != 0. cnt=0 in the first RUN cycle; oneshot is latched then.
  - RUN, cnt < P-1: cnt increments.
  - RUN, cnt == P-1: wrap=1 that cycle. Next cycle cnt=0 and toggle inverts. If the latched mode is oneshot, the next state is DONE, otherwise RUN.
  - DONE -> RUN on start with en=1, same conditions as from IDLE.
  - Any state -> IDLE the cycle after en=0. en=0 wins over a simultaneous start. toggle holds its value; done clears.
  - start while already in RUN is ignored; it does not restart the period.
  - start with active period = 0 is ignored; the channel stays in IDLE/DONE.
- Pulse: active when state==RUN and cnt < W_eff, where W_eff = min(W, P).
  - W=0: never active.
  - W>=P: active for the whole of RUN.
  - Decoded from registered cnt/state; asserts in the same cycle cnt=0 is first seen.
- Config shadowing:
  - cfg_load copies cfg_period/cfg_width into the shadow the next cycle.
  - Active values take the shadow in IDLE/DONE immediately, or in RUN at the wrap cycle (first cycle of the new period).
  - cfg_load coincident with wrap is applied at that wrap.
  - A second cfg_load before the wrap overwrites the shadow; the last one wins.
- P=1: wrap every cycle, cnt stays 0, toggle inverts every cycle.
- Counter width: cnt is CNT_W bits and never exceeds P-1, so there is no overflow. P = 2^CNT_W-1 is legal.
- busy = (state==RUN); done = (state==DONE). Both are registered state decodes.

Decomposition:
- Package periodic_pulse_pkg: state enum (IDLE/RUN/DONE) and the state-width localparam.
- One sub-module ppg_channel holds the counter, FSM, shadow/active registers and output decode; it is instantiated NUM_CH times in a generate loop.
- The divider and the vector slicing stay in the top level of the block.

Test Plan:
- Reset mid-RUN (P=10, assert sys_reset at cnt=4, no clock edge) -> all outputs go to their reset values immediately; ACT_LOW=1 gives pulse=1.
- Continuous run, P=5, W=2, start on ch0 -> pulse high 2 of every 5 cycles; wrap at cnt=4; toggle inverts every 5 cycles; busy stays 1.
- Oneshot, P=4, W=1 -> exactly one pulse and one wrap, then done=1/busy=0. A re-start gives one more period.
- Reconfigure in RUN, P=8 -> P=3 with cfg_load at cnt=2 -> current period completes at 8 cycles; following periods are 3 cycles.
- Edge values: P=0 with start stays IDLE; P=1/W=1 gives wrap and pulse every cycle; W=7 with P=4 gives pulse constantly high.
- Simultaneous en=0 and start on ch1 while ch2 runs -> ch1 goes to IDLE, ch2 is unaffected; clk_div with DIV=4 has a period of 4 cycles throughout.

Source files
------------

// File: rtl/periodic_pulse_pkg.sv
// Shared types for the periodic pulse generator: per-channel FSM state encoding.
package periodic_pulse_pkg;

    localparam int ST_W = 2;

    typedef enum logic [ST_W-1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } ch_state_e;

endpackage

// File: rtl/ppg_channel.sv
// One pulse channel: period counter, IDLE/RUN/DONE FSM, shadowed period/width
// and output decode from the registered state.
module ppg_channel
    import periodic_pulse_pkg::*;
#(
    parameter int CNT_W   = 32,
    parameter bit ACT_LOW = 1'b0
) (
    input  logic             sys_clk,
    input  logic             sys_reset,
    input  logic             en,
    input  logic             start,
    input  logic             oneshot,
    input  logic             cfg_load,
    input  logic [CNT_W-1:0] cfg_period,
    input  logic [CNT_W-1:0] cfg_width,
    output logic             pulse,
    output logic             wrap,
    output logic             toggle,
    output logic             busy,
    output logic             done
);

    ch_state_e        state, state_nxt;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] shd_p, shd_w;
    logic [CNT_W-1:0] act_p, act_w;
    logic [CNT_W-1:0] nxt_p, nxt_w;
    logic             mode_os;
    logic             start_ok;
    logic             take_cfg;

    // A load landing on a boundary cycle is forwarded so it is not a period late.
    assign nxt_p    = cfg_load ? cfg_period : shd_p;
    assign nxt_w    = cfg_load ? cfg_width  : shd_w;
    assign wrap     = (state == ST_RUN) && (cnt == act_p - CNT_W'(1));
    assign start_ok = en && start && (act_p != '0);

    always_comb begin
        state_nxt = state;
        take_cfg  = 1'b0;
        case (state)
            ST_IDLE, ST_DONE: begin
                take_cfg = 1'b1;
                if (start_ok) state_nxt = ST_RUN;
            end
            ST_RUN: begin
                if (wrap) begin
                    take_cfg = 1'b1;
                    // A zero period arriving at a boundary stops the channel
                    // rather than letting the counter run away.
                    if (nxt_p == '0)  state_nxt = ST_IDLE;
                    else if (mode_os) state_nxt = ST_DONE;
                    else              state_nxt = ST_RUN;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
        if (!en) state_nxt = ST_IDLE;
    end

    always_ff @(posedge sys_clk or posedge sys_reset) begin
        if (sys_reset) begin
            state   <= ST_IDLE;
            cnt     <= '0;
            shd_p   <= '0;
            shd_w   <= '0;
            act_p   <= '0;
            act_w   <= '0;
            mode_os <= 1'b0;
            toggle  <= 1'b0;
        end else begin
            state <= state_nxt;
            if (cfg_load) begin
                shd_p <= cfg_period;
                shd_w <= cfg_width;
            end
            if (take_cfg) begin
                act_p <= nxt_p;
                act_w <= nxt_w;
            end
            if (state != ST_RUN && state_nxt == ST_RUN) mode_os <= oneshot;
            cnt <= (state == ST_RUN && state_nxt == ST_RUN && !wrap) ? cnt + CNT_W'(1) : '0;
            if (wrap && en) toggle <= ~toggle;
        end
    end

    // cnt never exceeds P-1, so cnt < W already covers the W >= P case.
    assign pulse = ((state == ST_RUN) && (cnt < act_w)) ^ ACT_LOW;
    assign busy  = (state == ST_RUN);
    assign done  = (state == ST_DONE);

endmodule

// File: rtl/periodic_pulse_gen.sv
// Multi-channel periodic pulse / heartbeat generator with a free-running
// divided clock; channels are independent ppg_channel instances.
module periodic_pulse_gen
    import periodic_pulse_pkg::*;
#(
    parameter int NUM_CH  = 3,
    parameter int CNT_W   = 32,
    parameter int DIV     = 2,
    parameter int ACT_LOW = 0
) (
    input  logic                    sys_clk,
    input  logic                    sys_reset,
    input  logic [NUM_CH-1:0]       en,
    input  logic [NUM_CH-1:0]       start,
    input  logic [NUM_CH-1:0]       oneshot,
    input  logic [NUM_CH-1:0]       cfg_load,
    input  logic [NUM_CH*CNT_W-1:0] cfg_period,
    input  logic [NUM_CH*CNT_W-1:0] cfg_width,
    output logic [NUM_CH-1:0]       pulse,
    output logic [NUM_CH-1:0]       wrap,
    output logic [NUM_CH-1:0]       toggle,
    output logic [NUM_CH-1:0]       busy,
    output logic [NUM_CH-1:0]       done,
    output logic                    clk_div
);

    localparam int HALF = DIV / 2;
    localparam int DCW  = (HALF > 1) ? $clog2(HALF) : 1;

    logic [DCW-1:0]                div_cnt;
    logic [NUM_CH-1:0][CNT_W-1:0]  per_v, wid_v;

    always_ff @(posedge sys_clk or posedge sys_reset) begin
        if (sys_reset) begin
            div_cnt <= '0;
            clk_div <= 1'b0;
        end else if (div_cnt == DCW'(HALF - 1)) begin
            div_cnt <= '0;
            clk_div <= ~clk_div;
        end else begin
            div_cnt <= div_cnt + DCW'(1);
        end
    end

    assign per_v = cfg_period;
    assign wid_v = cfg_width;

    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
        ppg_channel #(
            .CNT_W   (CNT_W),
            .ACT_LOW (ACT_LOW != 0)
        ) u_ch (
            .sys_clk    (sys_clk),
            .sys_reset  (sys_reset),
            .en         (en[gi]),
            .start      (start[gi]),
            .oneshot    (oneshot[gi]),
            .cfg_load   (cfg_load[gi]),
            .cfg_period (per_v[gi]),
            .cfg_width  (wid_v[gi]),
            .pulse      (pulse[gi]),
            .wrap       (wrap[gi]),
            .toggle     (toggle[gi]),
            .busy       (busy[gi]),
            .done       (done[gi])
        );
    end

endmodule
